zap_mem_request_unit: RTL and testbench

Data-side memory request stage between the ALU stage and the data cache; its outputs feed the memory stage, which rotates and extends load data. It turns one ALU-stage load/store into a single cache bus cycle. It drives byte enables and store lane replication consistent with the memory stage's big-endian byte extraction, and stalls the pipeline until the cache acknowledges. It also captures read data and fault codes for the memory stage.

---
 rtl/zap_mem_pkg.sv | 35 +++
 rtl/zap_mem_request_unit_if.sv | 29 ++
 rtl/zap_mem_lane_gen.sv | 45 ++++
 rtl/zap_mem_request_unit.sv | 172 +++++++++++++++++
 tb/tb_zap_mem_request_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/zap_mem_pkg.sv
// ============================================================================
// Module   : zap_mem_pkg
// Purpose  : Shared types and constants for the data-side memory request unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package zap_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } mem_state_t;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_ALIGN = 2'b11;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } mem_size_t;

  // Byte flags take priority over halfword flags; no flag means a word access.
  function automatic mem_size_t decode_size(input logic sbyte, input logic ubyte,
                                            input logic shalf, input logic uhalf);
    if (sbyte || ubyte)      return SZ_BYTE;
    else if (shalf || uhalf) return SZ_HALF;
    else                     return SZ_WORD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zap_mem_request_unit_if.sv
// ============================================================================
// Module   : zap_mem_request_unit_if
// Purpose  : Data cache bus between the memory request unit and the D-cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface zap_mem_request_unit_if;
  logic        dc_stb;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [3:0]  dc_sel;
  logic [31:0] dc_wdata;
  logic        dc_ack;
  logic [31:0] dc_rdata;
  logic [1:0]  dc_err;

  modport master (
    output dc_stb, dc_we, dc_addr, dc_sel, dc_wdata,
    input  dc_ack, dc_rdata, dc_err
  );

  modport slave (
    input  dc_stb, dc_we, dc_addr, dc_sel, dc_wdata,
    output dc_ack, dc_rdata, dc_err
  );
endinterface

`default_nettype wire

// File: rtl/zap_mem_lane_gen.sv
// ============================================================================
// Module   : zap_mem_lane_gen
// Purpose  : Byte-enable and store-lane replication from size and addr[1:0].
//            ZAP_BIG_ENDIAN_BYTE_LANES_EN selects big-endian byte lanes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zap_mem_lane_gen
  import zap_mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  sel,
  output logic [31:0] wdata
);

  always_comb begin
    sel   = 4'b1111;
    wdata = data;
    case (size)
      SZ_HALF: begin
        sel   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      SZ_BYTE: begin
`ifdef ZAP_BIG_ENDIAN_BYTE_LANES_EN
        // Address 0 lands in bits [31:24], where the memory stage extracts it.
        sel   = 4'b1000 >> addr_lo;
`else
        sel   = 4'b0001 << addr_lo;
`endif
        wdata = {4{data[7:0]}};
      end
      default: begin
        sel   = 4'b1111;
        wdata = data;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/zap_mem_request_unit.sv
// ============================================================================
// Module   : zap_mem_request_unit
// Purpose  : Turns one ALU-stage load/store into a single D-cache bus cycle,
//            stalling until ack. Byte lanes follow ZAP_BIG_ENDIAN_BYTE_LANES_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zap_mem_request_unit
  import zap_mem_pkg::*;
#(
  parameter int PHY_REGS = 46
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_mem_req,
  input  logic                        i_mem_load,
  input  logic [31:0]                 i_mem_addr,
  input  logic [31:0]                 i_mem_wdata,
  input  logic                        i_sbyte,
  input  logic                        i_ubyte,
  input  logic                        i_shalf,
  input  logic                        i_uhalf,
  input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index,
  zap_mem_request_unit_if.master      dc,
  output logic                        o_data_stall,
  output logic                        o_mem_load_ff,
  output logic                        o_sbyte_ff,
  output logic                        o_ubyte_ff,
  output logic                        o_shalf_ff,
  output logic                        o_uhalf_ff,
  output logic [1:0]                  o_mem_address_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
  output logic [31:0]                 o_mem_rd_data,
  output logic [1:0]                  o_mem_fault
);

  mem_state_t  state, state_nxt;
  mem_size_t   size;
  logic        align_fault;
  logic        accept;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;

  logic        stb, stb_nxt;
  logic        we, we_nxt;
  logic [31:0] addr, addr_nxt;
  logic [3:0]  sel, sel_nxt;
  logic [31:0] wdata, wdata_nxt;
  logic [31:0] rd_data, rd_data_nxt;
  logic [1:0]  fault, fault_nxt;

  assign size        = decode_size(i_sbyte, i_ubyte, i_shalf, i_uhalf);
  assign align_fault = (size == SZ_HALF) && i_mem_addr[0];

  zap_mem_lane_gen u_lane_gen (
    .size    (size),
    .addr_lo (i_mem_addr[1:0]),
    .data    (i_mem_wdata),
    .sel     (lane_sel),
    .wdata   (lane_wdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      stb     <= 1'b0;
      we      <= 1'b0;
      addr    <= 32'd0;
      sel     <= 4'd0;
      wdata   <= 32'd0;
      rd_data <= 32'd0;
      fault   <= FLT_NONE;
    end else begin
      state   <= state_nxt;
      stb     <= stb_nxt;
      we      <= we_nxt;
      addr    <= addr_nxt;
      sel     <= sel_nxt;
      wdata   <= wdata_nxt;
      rd_data <= rd_data_nxt;
      fault   <= fault_nxt;
    end
  end

  // Fault is a one-cycle pulse: it defaults to none and is only set on the
  // cycle following an alignment error or a completed, unflushed ack.
  always_comb begin
    state_nxt   = state;
    stb_nxt     = stb;
    we_nxt      = we;
    addr_nxt    = addr;
    sel_nxt     = sel;
    wdata_nxt   = wdata;
    rd_data_nxt = rd_data;
    fault_nxt   = FLT_NONE;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (i_mem_req && !i_clear_from_writeback) begin
          if (align_fault) begin
            fault_nxt = FLT_ALIGN;
          end else begin
            accept    = 1'b1;
            stb_nxt   = 1'b1;
            we_nxt    = !i_mem_load;
            addr_nxt  = {i_mem_addr[31:2], 2'b00};
            sel_nxt   = lane_sel;
            wdata_nxt = lane_wdata;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (dc.dc_ack) begin
          stb_nxt   = 1'b0;
          state_nxt = IDLE;
          if (!i_clear_from_writeback) begin
            rd_data_nxt = dc.dc_rdata;
            fault_nxt   = dc.dc_err;
          end
        end else if (i_clear_from_writeback) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The bus cycle is never abandoned; its result is simply dropped.
        if (dc.dc_ack) begin
          stb_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        stb_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mem_load_ff          <= 1'b0;
      o_sbyte_ff             <= 1'b0;
      o_ubyte_ff             <= 1'b0;
      o_shalf_ff             <= 1'b0;
      o_uhalf_ff             <= 1'b0;
      o_mem_address_ff       <= 2'd0;
      o_mem_srcdest_index_ff <= '0;
    end else if (accept) begin
      o_mem_load_ff          <= i_mem_load;
      o_sbyte_ff             <= i_sbyte;
      o_ubyte_ff             <= i_ubyte;
      o_shalf_ff             <= i_shalf;
      o_uhalf_ff             <= i_uhalf;
      o_mem_address_ff       <= i_mem_addr[1:0];
      o_mem_srcdest_index_ff <= i_mem_srcdest_index;
    end
  end

  assign dc.dc_stb     = stb;
  assign dc.dc_we      = we;
  assign dc.dc_addr    = addr;
  assign dc.dc_sel     = sel;
  assign dc.dc_wdata   = wdata;
  assign o_data_stall  = (state == WAIT) || (state == DRAIN);
  assign o_mem_rd_data = rd_data;
  assign o_mem_fault   = fault;

endmodule

`default_nettype wire

// File: tb/tb_zap_mem_request_unit.sv
// ============================================================================
// Module   : tb_zap_mem_request_unit
// Purpose  : Scoreboard bench for the memory request unit and its cache bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_zap_mem_request_unit;
  import zap_mem_pkg::*;

  localparam int PHY_REGS = 46;
  localparam int IW       = $clog2(PHY_REGS);

  logic          clk = 1'b0;
  logic          reset, clear, req, load;
  logic [31:0]   addr, wd;
  logic          sbyte, ubyte, shalf, uhalf;
  logic [IW-1:0] sd;
  logic          stall, load_ff, sbyte_ff, ubyte_ff, shalf_ff, uhalf_ff;
  logic [1:0]    addr_ff, fault;
  logic [IW-1:0] sd_ff;
  logic [31:0]   rd_data;

  zap_mem_request_unit_if bus ();

  always #5 clk = ~clk;

  zap_mem_request_unit #(.PHY_REGS(PHY_REGS)) dut (
    .i_clk                  (clk),
    .i_reset                (reset),
    .i_clear_from_writeback (clear),
    .i_mem_req              (req),
    .i_mem_load             (load),
    .i_mem_addr             (addr),
    .i_mem_wdata            (wd),
    .i_sbyte                (sbyte),
    .i_ubyte                (ubyte),
    .i_shalf                (shalf),
    .i_uhalf                (uhalf),
    .i_mem_srcdest_index    (sd),
    .dc                     (bus),
    .o_data_stall           (stall),
    .o_mem_load_ff          (load_ff),
    .o_sbyte_ff             (sbyte_ff),
    .o_ubyte_ff             (ubyte_ff),
    .o_shalf_ff             (shalf_ff),
    .o_uhalf_ff             (uhalf_ff),
    .o_mem_address_ff       (addr_ff),
    .o_mem_srcdest_index_ff (sd_ff),
    .o_mem_rd_data          (rd_data),
    .o_mem_fault            (fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0]   rd;
    logic [1:0]    flt;
    logic          load;
    logic [1:0]    alo;
    logic [3:0]    flags;
    logic [IW-1:0] sd;
  } res_t;

  bus_t          bus_q[$];
  res_t          res_q[$];
  logic [31:0]   last_rd = 32'd0;
  logic [IW-1:0] sd_ctr  = '0;

  // flags = {sbyte, ubyte, shalf, uhalf}
  function automatic void exp_lanes(input logic [3:0] fl, input logic [1:0] a,
                                    input logic [31:0] d,
                                    output logic [3:0] s, output logic [31:0] w);
    if (fl[3] || fl[2]) begin
      w = {d[7:0], d[7:0], d[7:0], d[7:0]};
      case (a)
`ifdef ZAP_BIG_ENDIAN_BYTE_LANES_EN
        2'd0: s = 4'b1000;
        2'd1: s = 4'b0100;
        2'd2: s = 4'b0010;
        default: s = 4'b0001;
`else
        2'd0: s = 4'b0001;
        2'd1: s = 4'b0010;
        2'd2: s = 4'b0100;
        default: s = 4'b1000;
`endif
      endcase
    end else if (fl[1] || fl[0]) begin
      w = {d[15:0], d[15:0]};
      s = (a >= 2'd2) ? 4'b1100 : 4'b0011;
    end else begin
      w = d;
      s = 4'b1111;
    end
  endfunction

  // Call at a negedge; returns at the negedge of the cycle after the ack edge.
  // clr_at: stall cycle (1-based) in which clear pulses, or 0 for none.
  task automatic access(input logic ld, input logic [3:0] fl, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdat,
                        input logic [1:0] e, input int dly, input int clr_at);
    bus_t b;
    res_t r;
    logic [3:0]  s;
    logic [31:0] w;
    exp_lanes(fl, a[1:0], d, s, w);
    b.we = !ld; b.addr = {a[31:2], 2'b00}; b.sel = s; b.wdata = w;
    bus_q.push_back(b);
    if (clr_at > 0) begin
      r.rd = last_rd; r.flt = 2'b00;
    end else begin
      r.rd = rdat; r.flt = e; last_rd = rdat;
    end
    r.load = ld; r.alo = a[1:0]; r.flags = fl; r.sd = sd_ctr;
    res_q.push_back(r);

    req = 1'b1; load = ld; {sbyte, ubyte, shalf, uhalf} = fl;
    addr = a; wd = d; sd = sd_ctr;
    sd_ctr = (sd_ctr == IW'(PHY_REGS - 1)) ? '0 : sd_ctr + 1'b1;
    @(negedge clk);
    req = 1'b0;
    b = bus_q.pop_front();
    for (int k = 1; k <= dly; k++) begin
      check("stall_wait", stall, 1);
      check("stb_wait", bus.dc_stb, 1);
      check("we", bus.dc_we, b.we);
      check("addr", bus.dc_addr, b.addr);
      check("sel", bus.dc_sel, b.sel);
      check("wdata", bus.dc_wdata, b.wdata);
      clear = (k == clr_at);
      if (k == dly) begin
        bus.dc_ack = 1'b1; bus.dc_rdata = rdat; bus.dc_err = e;
      end
      @(negedge clk);
      bus.dc_ack = 1'b0; clear = 1'b0;
    end
    r = res_q.pop_front();
    check("stall_done", stall, 0);
    check("stb_done", bus.dc_stb, 0);
    check("rd_data", rd_data, r.rd);
    check("fault", fault, r.flt);
    check("load_ff", load_ff, r.load);
    check("addr_ff", addr_ff, r.alo);
    check("flags_ff", {sbyte_ff, ubyte_ff, shalf_ff, uhalf_ff}, r.flags);
    check("sd_ff", sd_ff, r.sd);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; req = 1'b0; load = 1'b0; addr = 32'd0; wd = 32'd0;
    {sbyte, ubyte, shalf, uhalf} = 4'b0000; sd = '0;
    bus.dc_ack = 1'b0; bus.dc_rdata = 32'd0; bus.dc_err = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_stb", bus.dc_stb, 0);
    check("rst_we", bus.dc_we, 0);
    check("rst_sel", bus.dc_sel, 0);
    check("rst_fault", fault, 0);
    check("rst_stall", stall, 0);
    check("rst_load_ff", load_ff, 0);
    check("rst_rd", rd_data, 0);
    check("rst_flags", {sbyte_ff, ubyte_ff, shalf_ff, uhalf_ff}, 0);
    reset = 1'b0;
    @(negedge clk);

    access(1'b0, 4'b0000, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 2'b00, 3, 0);
    access(1'b1, 4'b0100, 32'h0000_2001, 32'h0, 32'h1122_3344, 2'b00, 1, 0);
    access(1'b0, 4'b0001, 32'h0000_3002, 32'h0000_ABCD, 32'h5555_0000, 2'b00, 2, 0);

    // misaligned halfword: no bus cycle, one-cycle align fault
    req = 1'b1; load = 1'b0; {sbyte, ubyte, shalf, uhalf} = 4'b0001; addr = 32'h0000_3003;
    @(negedge clk);
    req = 1'b0;
    check("align_stb", bus.dc_stb, 0);
    check("align_stall", stall, 0);
    check("align_fault", fault, FLT_ALIGN);
    check("align_rd", rd_data, last_rd);
    @(negedge clk);
    check("align_fault_clr", fault, 0);

    access(1'b1, 4'b0000, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 2'b01, 1, 0);
    @(negedge clk);
    check("err_fault_clr", fault, 0);

    // flush during WAIT, then a back-to-back request the next cycle
    access(1'b1, 4'b0000, 32'h0000_5008, 32'h0, 32'hBAD0_BAD0, 2'b10, 6, 2);
    access(1'b1, 4'b1000, 32'h0000_6003, 32'h0, 32'h0102_0304, 2'b00, 1, 0);
    // flush coinciding with ack
    access(1'b1, 4'b0010, 32'h0000_7002, 32'h0, 32'h7777_7777, 2'b01, 2, 2);

    for (int i = 0; i < 4; i++)
      access(1'b0, 4'b1000, 32'h0000_8000 + 32'(i), 32'h0000_00A0 + 32'(i),
             $urandom, 2'b00, 1 + (i % 2), 0);
    for (int i = 0; i < 2; i++)
      access(1'b1, 4'b0010, 32'h0000_9000 + 32'(2 * i), 32'h0, $urandom, 2'b00, 1, 0);

    // clear in IDLE: request ignored
    req = 1'b1; clear = 1'b1; load = 1'b1; {sbyte, ubyte, shalf, uhalf} = 4'b0000;
    addr = 32'h0000_A000;
    @(negedge clk);
    req = 1'b0; clear = 1'b0;
    check("idle_clr_stb", bus.dc_stb, 0);
    check("idle_clr_stall", stall, 0);

    // reset while waiting for ack
    req = 1'b1; addr = 32'h0000_B000;
    @(negedge clk);
    req = 1'b0;
    check("pre_rst_stb", bus.dc_stb, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_stb", bus.dc_stb, 0);
    check("mid_rst_stall", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
